// File: rtl/dragonfang_floating_point_pkg.sv
// Shared types for the vector FP min/max datapath and its issue/retire sequencer.
package dragonfang_floating_point_pkg;

    localparam int unsigned VLEN                 = 64;
    localparam int unsigned VFP_MINMAX_TAG_WIDTH = 4;
    localparam int unsigned VFP_MINMAX_LATENCY   = 2;

    typedef enum logic {
        VfpOpMin = 1'b0,
        VfpOpMax = 1'b1
    } vfp_minmax_op_e;

    typedef struct packed {
        vfp_minmax_op_e op;
        logic [1:0]     vsew;
        logic           vm;
    } execution_vector_t;

    typedef logic [VFP_MINMAX_TAG_WIDTH-1:0] vfp_minmax_tag_t;

    typedef struct packed {
        logic [VLEN-1:0] vd;
        vfp_minmax_tag_t tag;
    } vfp_minmax_rsp_t;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } vfp_minmax_seq_state_t;

endpackage

// File: rtl/vector_floating_point_result_fifo.sv
// Response FIFO for the min/max sequencer: synchronous write/pop, clear, occupancy count.
module vector_floating_point_result_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0]   mem_q [Depth];
    logic               full;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (count_o == '0);
    assign full      = (count_o == ($clog2(Depth) + 1)'(Depth));
    assign rd_data_o = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en_i && !clear_i) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wr_data_i;
        end
    end

    // Credits upstream are what keep this from ever firing.
    assert property (@(posedge clock_i) disable iff (reset_i) !(wr_en_i && full && !clear_i));

endmodule

// File: rtl/vector_floating_point_minmax_sequencer.sv
// Issue/retire controller for the registered vector FP min/max unit.
// Optional perf counters: define VFP_MINMAX_SEQ_PERF_COUNTERS_EN.
module vector_floating_point_minmax_sequencer
    import dragonfang_floating_point_pkg::*;
#(
    parameter int unsigned UNIT_LATENCY = VFP_MINMAX_LATENCY,
    parameter int unsigned RESULT_DEPTH = 4,
    parameter int unsigned TAG_WIDTH    = VFP_MINMAX_TAG_WIDTH
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  execution_vector_t     req_execution_vector_i,
    input  logic [VLEN-1:0]       req_vs2_i,
    input  logic [VLEN-1:0]       req_vs1_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output execution_vector_t     unit_execution_vector_o,
    output logic [VLEN-1:0]       unit_vs2_o,
    output logic [VLEN-1:0]       unit_vs1_o,
    input  logic [VLEN-1:0]       unit_vd_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [VLEN-1:0]       rsp_vd_o,
    output logic [TAG_WIDTH-1:0]  rsp_tag_o,
    input  logic                  flush_i,
`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
    output logic [31:0]           perf_issued_o,
    output logic [31:0]           perf_stall_o,
`endif
    output logic                  busy_o
);

    localparam int unsigned CreditW = $clog2(RESULT_DEPTH + 1);
    localparam int unsigned DrainW  = $clog2(UNIT_LATENCY + 1);
    localparam int unsigned RspW    = VLEN + TAG_WIDTH;
    localparam logic [CreditW-1:0] CreditsFull = CreditW'(RESULT_DEPTH);
    localparam logic [DrainW-1:0]  DrainLoad   = DrainW'(UNIT_LATENCY);

    vfp_minmax_seq_state_t state_q, state_d;
    logic [CreditW-1:0]    credits_q, credits_d;
    logic [DrainW-1:0]     drain_q, drain_d;
    logic [UNIT_LATENCY-1:0]                pipe_vld_q, pipe_vld_d;
    logic [UNIT_LATENCY-1:0][TAG_WIDTH-1:0] pipe_tag_q, pipe_tag_d;

    logic                        in_run;
    logic                        fire;
    logic                        pop;
    logic                        fifo_wr;
    logic                        fifo_empty;
    logic [$clog2(RESULT_DEPTH):0] fifo_count;
    logic [RspW-1:0]             fifo_rd_data;

    assign in_run      = (state_q == StRun);
    assign req_ready_o = in_run && (credits_q != '0) && !flush_i;
    assign fire        = req_valid_i && req_ready_o;
    assign rsp_valid_o = !fifo_empty && in_run && !flush_i;
    assign pop         = rsp_valid_o && rsp_ready_i;
    // Results that surface while flushing belong to discarded work.
    assign fifo_wr     = pipe_vld_q[UNIT_LATENCY-1] && in_run && !flush_i;

    assign unit_execution_vector_o = fire ? req_execution_vector_i : '0;
    assign unit_vs2_o              = fire ? req_vs2_i : '0;
    assign unit_vs1_o              = fire ? req_vs1_i : '0;

    assign rsp_vd_o  = fifo_rd_data[RspW-1:TAG_WIDTH];
    assign rsp_tag_o = fifo_rd_data[TAG_WIDTH-1:0];
    assign busy_o    = !in_run || (pipe_vld_q != '0) || (fifo_count != '0);

    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_tag_d    = pipe_tag_q;
        pipe_vld_d[0] = fire;
        pipe_tag_d[0] = req_tag_i;
        for (int i = 1; i < UNIT_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        if (flush_i) begin
            pipe_vld_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        drain_d   = drain_q;
        unique case (state_q)
            StRun: begin
                if (flush_i) begin
                    state_d = StFlush;
                    drain_d = DrainLoad;
                end else if (fire && !pop) begin
                    credits_d = credits_q - CreditW'(1);
                end else if (pop && !fire) begin
                    credits_d = credits_q + CreditW'(1);
                end
            end
            StFlush: begin
                if (flush_i) begin
                    drain_d = DrainLoad;
                end else if (drain_q <= DrainW'(1)) begin
                    state_d   = StRun;
                    drain_d   = '0;
                    credits_d = CreditsFull;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StRun;
            credits_q  <= CreditsFull;
            drain_q    <= '0;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            drain_q    <= drain_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
        end
    end

    vector_floating_point_result_fifo #(
        .Width (RspW),
        .Depth (RESULT_DEPTH)
    ) u_result_fifo (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (flush_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({unit_vd_i, pipe_tag_q[UNIT_LATENCY-1]}),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (fire && (perf_issued_q != '1)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (req_valid_i && !req_ready_o && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_floating_point_minmax_sequencer.sv
// Directed bench for the min/max sequencer with a stand-in two-stage unit and a response scoreboard.
module tb_vector_floating_point_minmax_sequencer;
    import dragonfang_floating_point_pkg::*;

    localparam int unsigned TW = 4;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    execution_vector_t req_ev;
    logic [VLEN-1:0]   req_vs2;
    logic [VLEN-1:0]   req_vs1;
    logic [TW-1:0]     req_tag;
    execution_vector_t unit_ev;
    logic [VLEN-1:0]   unit_vs2;
    logic [VLEN-1:0]   unit_vs1;
    logic [VLEN-1:0]   unit_vd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [VLEN-1:0]   rsp_vd;
    logic [TW-1:0]     rsp_tag;
    logic              flush;
    logic              busy;
`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
    logic [31:0]       perf_issued;
    logic [31:0]       perf_stall;
    logic [31:0]       base_issued;
    logic [31:0]       base_stall;
`endif

    typedef struct packed {
        logic [VLEN-1:0] vd;
        logic [TW-1:0]   tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   acc;
    int   lat;
    int   seen;

    vector_floating_point_minmax_sequencer dut (
        .clock_i                 (clock),
        .reset_i                 (reset),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .req_execution_vector_i  (req_ev),
        .req_vs2_i               (req_vs2),
        .req_vs1_i               (req_vs1),
        .req_tag_i               (req_tag),
        .unit_execution_vector_o (unit_ev),
        .unit_vs2_o              (unit_vs2),
        .unit_vs1_o              (unit_vs1),
        .unit_vd_i               (unit_vd),
        .rsp_valid_o             (rsp_valid),
        .rsp_ready_i             (rsp_ready),
        .rsp_vd_o                (rsp_vd),
        .rsp_tag_o               (rsp_tag),
        .flush_i                 (flush),
`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
        .perf_issued_o           (perf_issued),
        .perf_stall_o            (perf_stall),
`endif
        .busy_o                  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Maps FP32 bit patterns onto an unsigned total order (non-NaN values).
    function automatic logic [31:0] ord_key(input logic [31:0] f);
        return f[31] ? ~f : (f | 32'h8000_0000);
    endfunction

    function automatic logic [VLEN-1:0] ref_minmax(input execution_vector_t ev,
                                                   input logic [VLEN-1:0] a,
                                                   input logic [VLEN-1:0] b);
        logic [VLEN-1:0] r;
        logic [31:0]     x;
        logic [31:0]     y;
        logic            lt;
        r = '0;
        for (int l = 0; l < VLEN / 32; l++) begin
            x  = a[l*32 +: 32];
            y  = b[l*32 +: 32];
            lt = ord_key(x) < ord_key(y);
            r[l*32 +: 32] = (ev.op == VfpOpMax) ? (lt ? y : x) : (lt ? x : y);
        end
        return r;
    endfunction

    // Stand-in unit: registered inputs, registered result.
    execution_vector_t u_ev;
    logic [VLEN-1:0]   u_a;
    logic [VLEN-1:0]   u_b;
    always_ff @(posedge clock) begin
        u_ev    <= unit_ev;
        u_a     <= unit_vs2;
        u_b     <= unit_vs1;
        unit_vd <= ref_minmax(u_ev, u_a, u_b);
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [TW-1:0] tag);
        req_valid = 1'b1;
        req_tag   = tag;
        req_ev.op = tag[0] ? VfpOpMax : VfpOpMin;
        req_vs2   = {$urandom, $urandom};
        req_vs1   = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        @(negedge clock);
        while (busy && c < 40) begin
            next_cycle();
            c++;
            @(negedge clock);
        end
        check(name, {63'd0, busy}, 64'd0);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: push on accepted request, pop and compare on retired response.
    always @(negedge clock) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (req_valid && req_ready) begin
                sb.push_back({ref_minmax(req_ev, req_vs2, req_vs1), req_tag});
            end
            if (rsp_valid && rsp_ready) begin
                seen++;
                check("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    check("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
                    check("rsp_vd", rsp_vd, sb[0].vd);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; seen = 0;
        reset = 1'b1; req_valid = 1'b0; req_ev = '0; req_vs2 = '0; req_vs1 = '0;
        req_tag = '0; rsp_ready = 1'b0; flush = 1'b0;

        // Reset values
        @(negedge clock);
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_unit_vs2", unit_vs2, 64'd0);
        next_cycle();
        reset = 1'b0;

        // Single op, tag 3
        next_cycle();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_tag = 4'd3; req_ev.op = VfpOpMax;
        req_vs2 = 64'h3f80_0000_c000_0000;
        req_vs1 = 64'h4000_0000_bf80_0000;
        @(negedge clock);
        check("fire_unit_vs2", unit_vs2, 64'h3f80_0000_c000_0000);
        check("fire_unit_vs1", unit_vs1, 64'h4000_0000_bf80_0000);
        next_cycle();
        req_valid = 1'b0;
        lat = 1;
        @(negedge clock);
        check("idle_unit_vs2", unit_vs2, 64'd0);
        while (!rsp_valid && lat < 10) begin
            next_cycle();
            lat++;
            @(negedge clock);
        end
        check("single_latency", 64'(lat), 64'd3);
        check("single_tag", 64'(rsp_tag), 64'd3);
        check("single_vd", rsp_vd, 64'h4000_0000_bf80_0000);
        next_cycle();
        wait_idle("single_idle");

`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
        base_issued = perf_issued;
        base_stall  = perf_stall;
`endif
        // Six back-to-back requests against a stalled consumer
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            set_req(TW'(k));
            @(negedge clock);
            check("credit_ready", {63'd0, req_ready}, (k < 4) ? 64'd1 : 64'd0);
            if (req_ready) acc++;
        end
        next_cycle();
        req_valid = 1'b0;
        check("credit_accepted", 64'(acc), 64'd4);
        repeat (4) next_cycle();
        @(negedge clock);
        check("full_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("full_head_tag", 64'(rsp_tag), 64'd0);
        check("full_req_ready", {63'd0, req_ready}, 64'd0);
`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
        check("perf_issued", 64'(perf_issued - base_issued), 64'd4);
        check("perf_stall", 64'(perf_stall - base_stall), 64'd2);
`endif

        // Release the consumer while requesting every cycle
        next_cycle();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_req(TW'(k + 8));
            @(negedge clock);
            check("steady_ready", {63'd0, req_ready}, (k != 0) ? 64'd1 : 64'd0);
            next_cycle();
        end
        req_valid = 1'b0;
        wait_idle("steady_idle");

        // Flush one cycle after issuing tags 5 and 6
        next_cycle();
        set_req(4'd5);
        next_cycle();
        set_req(4'd6);
        next_cycle();
        set_req(4'd7);
        flush = 1'b1;
        seen = 0;
        @(negedge clock);
        check("flush_ready_c0", {63'd0, req_ready}, 64'd0);
        check("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        next_cycle();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        check("flush_ready_c1", {63'd0, req_ready}, 64'd0);
        check("flush_busy_c1", {63'd0, busy}, 64'd1);
        next_cycle();
        @(negedge clock);
        check("flush_ready_c2", {63'd0, req_ready}, 64'd0);
        next_cycle();
        @(negedge clock);
        check("flush_ready_c3", {63'd0, req_ready}, 64'd1);
        check("flush_busy_c3", {63'd0, busy}, 64'd0);
        repeat (6) next_cycle();
        check("flush_no_rsp", 64'(seen), 64'd0);

        // Credits restored to full depth after the drain
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            set_req(TW'(k + 1));
            @(negedge clock);
            if (req_ready) acc++;
        end
        next_cycle();
        req_valid = 1'b0;
        check("flush_credits", 64'(acc), 64'd4);
        rsp_ready = 1'b1;
        wait_idle("flush_drain_idle");

        // Asynchronous reset with two ops in flight
        next_cycle();
        set_req(4'd1);
        next_cycle();
        set_req(4'd2);
        next_cycle();
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("areset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("areset_req_ready", {63'd0, req_ready}, 64'd1);
        check("areset_busy", {63'd0, busy}, 64'd0);
        next_cycle();
        reset = 1'b0;
        seen = 0;
        repeat (8) next_cycle();
        check("areset_no_stale", 64'(seen), 64'd0);
`ifdef VFP_MINMAX_SEQ_PERF_COUNTERS_EN
        check("areset_perf_issued", 64'(perf_issued), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
